// File: rtl/intr_request_unit_pkg.sv
// Shared interrupt constants: source count, CPU vector addresses and CP0 register indices.
package intr_request_unit_pkg;

  localparam int unsigned N_SRC_DEFAULT = 3;

  // Exception vectors taken by the core for each source
  localparam logic [31:0] IRQ_VEC_SRC2 = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC_SRC1 = 32'h0000_0600;
  localparam logic [31:0] IRQ_VEC_SRC0 = 32'h0000_0800;

  localparam logic [4:0] CP0_REG_DISABLE = 5'h16;
  localparam logic [4:0] CP0_REG_MASK    = 5'h17;
  localparam logic [4:0] CP0_REG_EPC     = 5'h0E;

  function automatic logic [31:0] irq_vector(input int unsigned src);
    unique case (src)
      2:       irq_vector = IRQ_VEC_SRC2;
      1:       irq_vector = IRQ_VEC_SRC1;
      default: irq_vector = IRQ_VEC_SRC0;
    endcase
  endfunction

endpackage

// File: rtl/intr_request_unit_prio_enc.sv
// Highest-set-bit one-hot priority encoder; all-zero output for all-zero input.
module intr_request_unit_prio_enc #(
  parameter int unsigned Width = 3
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] gnt_o
);

  // Scanning upward lets the highest set bit overwrite lower ones
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_request_unit.sv
// Interrupt request front-end: edge detect, pending latch, mask/disable gating, priority grant.
// Define IRQ_SYNC_EN to add a two-flop synchronizer on irq_in for asynchronous sources.
module intr_request_unit
  import intr_request_unit_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             irq_disable,
  output logic [N_SRC-1:0] irq_grant,
  output logic [N_SRC-1:0] irq_pending
);

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // prev resets to 0 so a line already high at reset release counts as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= irq_s;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rise = irq_s & ~prev_q;
    elig = irq_disable ? '0 : (pending_q & ~irq_mask);
    // A fresh edge wins over consumption by the grant
    pending_d = rise | (pending_q & ~irq_grant);
  end

  intr_request_unit_prio_enc #(
    .Width (N_SRC)
  ) u_prio_enc (
    .req_i (elig),
    .gnt_o (irq_grant)
  );

  assign irq_pending = pending_q;

endmodule

// File: tb/tb_intr_request_unit.sv
// Scoreboard bench for intr_request_unit against a behavioural model of the request rules.
module tb_intr_request_unit;
  import intr_request_unit_pkg::*;

  localparam int unsigned N = N_SRC_DEFAULT;
`ifdef IRQ_SYNC_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 0;
`endif

  typedef struct packed {
    logic [N-1:0] pend;
    logic [N-1:0] gnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] irq_mask = '0;
  logic         irq_disable = 1'b0;
  logic [N-1:0] irq_grant;
  logic [N-1:0] irq_pending;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sbq[$];

  // Model state: what each source "has seen" and what is waiting to be served
  logic [N-1:0] m_pend;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_hist[$];

  intr_request_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (irq_in),
    .irq_mask    (irq_mask),
    .irq_disable (irq_disable),
    .irq_grant   (irq_grant),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endfunction

  // Highest-numbered eligible source wins; nothing when globally disabled
  function automatic logic [N-1:0] model_grant(logic [N-1:0] pend, logic [N-1:0] mask,
                                               logic dis);
    logic [N-1:0] g = '0;
    if (dis) return g;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i] && !mask[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_hist.delete();
    for (int i = 0; i < Lat; i++) m_hist.push_back('0);
  endtask

  // One clock edge: the request line value seen is delayed by the synchronizer depth
  task automatic model_edge();
    logic [N-1:0] eff;
    logic [N-1:0] g;
    m_hist.push_back(irq_in);
    eff = m_hist.pop_front();
    g = model_grant(m_pend, irq_mask, irq_disable);
    for (int i = 0; i < N; i++) begin
      if (eff[i] && !m_prev[i]) m_pend[i] = 1'b1;
      else if (g[i]) m_pend[i] = 1'b0;
    end
    m_prev = eff;
  endtask

  task automatic step(logic [N-1:0] in, logic [N-1:0] mask, logic dis);
    exp_t e;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    irq_in      = in;
    irq_mask    = mask;
    irq_disable = dis;
    e.pend = m_pend;
    e.gnt  = model_grant(m_pend, mask, dis);
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("pending", irq_pending, e.pend);
        check("grant", irq_grant, e.gnt);
      end
    end
  end

  initial begin : stim
    logic [N-1:0] r_in, r_mask;
    logic         r_dis;
    model_reset();

    // Lines high throughout reset must each register once after release
    irq_in = '1;
    #12;
    check("reset_pending", irq_pending, '0);
    check("reset_grant", irq_grant, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step('1, '0, 1'b0);
    step('0, '0, 1'b0);

    // Long hold on source 0: one request only
    for (int i = 0; i < 35; i++) step(3'b001, '0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0);

    // Held while disabled, released when enabled
    step(3'b010, '0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0);

    // Masked high source waits, low source served
    step(3'b101, 3'b100, 1'b0);
    for (int i = 0; i < 5; i++) step('0, 3'b100, 1'b0);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0);

    // New edge on the edge its own grant is consumed
    step(3'b010, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1);
    step(3'b010, '0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0);

    // Asynchronous reset with a pending request held
    step(3'b010, '0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pending", irq_pending, '0);
    check("async_rst_grant", irq_grant, '0);
    model_reset();
    irq_disable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Random traffic
    r_in = '0;
    r_mask = '0;
    r_dis = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) r_in[b] = ~r_in[b];
      if ($urandom_range(7) == 0) r_mask = N'($urandom);
      if ($urandom_range(3) == 0) r_dis = ~r_dis;
      step(r_in, r_mask, r_dis);
    end
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
